// File: rtl/event_window_monitor.sv
// Liveness checker: after reset it waits a guard period, counts per-channel
// strobe activity over a fixed window and registers a pass/fail verdict.
module event_window_monitor #(
  parameter int NUM_CH     = 2,
  parameter int GUARD      = 2,
  parameter int WINDOW     = 10,
  parameter int CNT_W      = 4,
  parameter int EARLY_EXIT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ev,
  input  logic                    mon_rst,
  input  logic                    restart,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    mon_err,
  output logic [NUM_CH-1:0]       seen,
  output logic [NUM_CH-1:0]       fail_ch,
  output logic [NUM_CH*CNT_W-1:0] hit_cnt
);

  localparam int GW = $clog2(GUARD + 1);
  localparam int WW = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {S_GUARD, S_WINDOW, S_DONE} state_t;

  state_t                  state;
  logic [GW-1:0]           guard_cnt;
  logic [WW-1:0]           win_cnt;
  logic [NUM_CH*CNT_W-1:0] hit_next;
  logic [NUM_CH-1:0]       seen_next;
  logic                    all_seen;
  logic                    mon_err_next;
  logic                    close_window;

  // Per-channel saturating increment of the count as it will be after this edge.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cur;
      assign cur = hit_cnt[gi*CNT_W +: CNT_W];
      assign hit_next[gi*CNT_W +: CNT_W] =
        (ev[gi] && (cur != {CNT_W{1'b1}})) ? cur + CNT_W'(1) : cur;
      assign seen_next[gi] = |hit_next[gi*CNT_W +: CNT_W];
    end
  endgenerate

  assign all_seen     = &seen_next;
  assign mon_err_next = mon_err | mon_rst;
  assign close_window = (win_cnt == WW'(WINDOW - 1)) || ((EARLY_EXIT != 0) && all_seen);

  always_ff @(posedge clk) begin
    if (rst || ((state == S_DONE) && restart)) begin
      state     <= S_GUARD;
      guard_cnt <= '0;
      win_cnt   <= '0;
      hit_cnt   <= '0;
      mon_err   <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      seen      <= '0;
      fail_ch   <= '0;
    end else begin
      case (state)
        S_GUARD: begin
          if (guard_cnt == GW'(GUARD - 1)) begin
            state <= S_WINDOW;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end
        S_WINDOW: begin
          hit_cnt <= hit_next;
          seen    <= seen_next;
          mon_err <= mon_err_next;
          win_cnt <= win_cnt + WW'(1);
          // Verdict uses the counts including this edge's sample.
          if (close_window) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= all_seen & ~mon_err_next;
            fail    <= ~(all_seen & ~mon_err_next);
            fail_ch <= ~seen_next;
          end
        end
        S_DONE: begin
        end
        default: state <= S_GUARD;
      endcase
    end
  end

endmodule

// File: tb/tb_event_window_monitor.sv
// Scoreboard bench: three monitor instances (defaults, CNT_W=3, EARLY_EXIT=1)
// share one stimulus; each run checks the selected instance against a model.
module tb_event_window_monitor;

  localparam int GUARD  = 2;
  localparam int WINDOW = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ev = '0;
  logic       mon_rst = 1'b0;
  logic       restart = 1'b0;

  logic       busy0, done0, pass0, fail0, merr0;
  logic [1:0] seen0, fch0;
  logic [7:0] hit0;
  logic       busy1, done1, pass1, fail1, merr1;
  logic [1:0] seen1, fch1;
  logic [5:0] hit1;
  logic       busy2, done2, pass2, fail2, merr2;
  logic [1:0] seen2, fch2;
  logic [7:0] hit2;

  always #5 clk = ~clk;

  event_window_monitor dut0 (
    .clk(clk), .rst(rst), .ev(ev), .mon_rst(mon_rst), .restart(restart),
    .busy(busy0), .done(done0), .pass(pass0), .fail(fail0), .mon_err(merr0),
    .seen(seen0), .fail_ch(fch0), .hit_cnt(hit0));

  event_window_monitor #(.CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .ev(ev), .mon_rst(mon_rst), .restart(restart),
    .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .mon_err(merr1),
    .seen(seen1), .fail_ch(fch1), .hit_cnt(hit1));

  event_window_monitor #(.EARLY_EXIT(1)) dut2 (
    .clk(clk), .rst(rst), .ev(ev), .mon_rst(mon_rst), .restart(restart),
    .busy(busy2), .done(done2), .pass(pass2), .fail(fail2), .mon_err(merr2),
    .seen(seen2), .fail_ch(fch2), .hit_cnt(hit2));

  typedef struct {
    logic       done, pass, fail, mon_err, busy;
    logic [1:0] seen, fail_ch;
    logic [7:0] hit;
  } obs_t;

  typedef struct {
    string      tag;
    int         dedge;
    logic       pass, fail, mon_err;
    logic [1:0] fail_ch, seen;
    logic [7:0] hit;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [1:0] ev_pat [0:39];
  logic       mr_pat [0:39];
  logic       rs_pat [0:39];
  logic       exp_mon[0:39];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic obs_t get_obs(input int d);
    obs_t o;
    case (d)
      1: begin
        o.done = done1; o.pass = pass1; o.fail = fail1; o.mon_err = merr1;
        o.busy = busy1; o.seen = seen1; o.fail_ch = fch1; o.hit = {2'b00, hit1};
      end
      2: begin
        o.done = done2; o.pass = pass2; o.fail = fail2; o.mon_err = merr2;
        o.busy = busy2; o.seen = seen2; o.fail_ch = fch2; o.hit = hit2;
      end
      default: begin
        o.done = done0; o.pass = pass0; o.fail = fail0; o.mon_err = merr0;
        o.busy = busy0; o.seen = seen0; o.fail_ch = fch0; o.hit = hit0;
      end
    endcase
    return o;
  endfunction

  task automatic clear_pats();
    for (int e = 0; e < 40; e++) begin
      ev_pat[e] = 2'b00; mr_pat[e] = 1'b0; rs_pat[e] = 1'b0;
    end
  endtask

  // Behavioural model of one run; pushes the expected verdict to the scoreboard.
  task automatic predict(input string tag, input int d);
    exp_t x;
    int   c0, c1, cmax;
    logic m, early;
    cmax = (d == 1) ? 7 : 15;
    early = (d == 2);
    c0 = 0; c1 = 0; m = 1'b0;
    x.dedge = GUARD + WINDOW;
    for (int e = 0; e < 40; e++) exp_mon[e] = 1'b0;
    for (int k = 0; k < WINDOW; k++) begin
      int e;
      e = GUARD + 1 + k;
      if (ev_pat[e][0] && c0 < cmax) c0++;
      if (ev_pat[e][1] && c1 < cmax) c1++;
      m = m | mr_pat[e];
      exp_mon[e] = m;
      if (early && c0 != 0 && c1 != 0) begin
        x.dedge = e;
        break;
      end
    end
    for (int e = x.dedge + 1; e < 40; e++) exp_mon[e] = m;
    x.tag     = tag;
    x.mon_err = m;
    x.pass    = (c0 != 0) && (c1 != 0) && !m;
    x.fail    = !x.pass;
    x.seen    = {c1 != 0, c0 != 0};
    x.fail_ch = ~x.seen;
    x.hit     = (d == 1) ? {2'b00, c1[2:0], c0[2:0]} : {c1[3:0], c0[3:0]};
    sb.push_back(x);
  endtask

  // Edge E0 is a reset (do_reset=1) or a restart while in DONE (do_reset=0).
  task automatic run_test(input string tag, input int d, input logic do_reset, input int n_edges);
    obs_t o;
    exp_t x;
    bit   got;
    predict(tag, d);
    rst = do_reset; restart = !do_reset; ev = 2'b00; mon_rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; restart = 1'b0;
    o = get_obs(d);
    check({tag, ".clr_busy"}, o.busy, 1);
    check({tag, ".clr_flags"}, {o.done, o.pass, o.fail, o.mon_err}, 4'b0000);
    check({tag, ".clr_hit"}, o.hit, 0);
    check({tag, ".clr_seen"}, {o.seen, o.fail_ch}, 4'b0000);
    got = 1'b0;
    for (int e = 1; e <= n_edges; e++) begin
      ev = ev_pat[e]; mon_rst = mr_pat[e]; restart = rs_pat[e];
      @(posedge clk); @(negedge clk);
      o = get_obs(d);
      check($sformatf("%s.done_E%0d", tag, e), o.done, e >= sb[0].dedge);
      check($sformatf("%s.busy_E%0d", tag, e), o.busy, e < sb[0].dedge);
      check($sformatf("%s.mon_err_E%0d", tag, e), o.mon_err, exp_mon[e]);
      if (o.done && !got) begin
        got = 1'b1;
        x = sb.pop_front();
        check({tag, ".done_edge"}, e, x.dedge);
        check({tag, ".pass_fail"}, {o.pass, o.fail}, {x.pass, x.fail});
        check({tag, ".fail_ch"}, o.fail_ch, x.fail_ch);
        check({tag, ".seen"}, o.seen, x.seen);
        check({tag, ".hit"}, o.hit, x.hit);
        $display("run %s: done at E%0d pass=%0d fail=%0d fail_ch=%b hit=%h mon_err=%0d",
                 tag, e, o.pass, o.fail, o.fail_ch, o.hit, o.mon_err);
      end
    end
    ev = 2'b00; mon_rst = 1'b0; restart = 1'b0;
    if (!got) begin
      check({tag, ".timeout"}, 0, 1);
      x = sb.pop_front();
    end else begin
      o = get_obs(d);
      check({tag, ".hold_hit"}, o.hit, x.hit);
      check({tag, ".hold_verdict"}, {o.done, o.pass, o.fail, o.fail_ch},
            {1'b1, x.pass, x.fail, x.fail_ch});
    end
  endtask

  initial begin
    clear_pats();
    ev_pat[5] = 2'b01; ev_pat[7] = 2'b10;
    run_test("coverage", 0, 1'b1, 14);

    clear_pats();
    ev_pat[5] = 2'b01;
    run_test("missing", 0, 1'b1, 14);

    clear_pats();
    ev_pat[1] = 2'b11; ev_pat[2] = 2'b11; ev_pat[13] = 2'b11;
    run_test("masking", 0, 1'b1, 15);

    clear_pats();
    ev_pat[4] = 2'b11; mr_pat[8] = 1'b1; rs_pat[6] = 1'b1;
    run_test("mon_rst", 0, 1'b1, 14);

    clear_pats();
    for (int e = 3; e <= 12; e++) ev_pat[e] = 2'b01;
    run_test("sat_w3", 1, 1'b1, 13);
    run_test("sat_w4", 0, 1'b1, 13);

    clear_pats();
    ev_pat[4] = 2'b01; ev_pat[6] = 2'b10;
    run_test("early", 2, 1'b1, 14);

    // Partial run aborted by rst at E7; the following run's E0 is that rst.
    clear_pats();
    rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      ev = 2'b11; @(posedge clk); @(negedge clk);
    end
    ev = 2'b00;
    check("pre_abort.seen", seen0, 2'b11);
    ev_pat[5] = 2'b01; ev_pat[7] = 2'b10;
    run_test("mid_rst", 0, 1'b1, 13);
    run_test("restart", 0, 1'b0, 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_window_monitor.md
# event_window_monitor

- Synthesizable liveness checker for NUM_CH request-style strobes (wr/rd-class signals).
- After reset release it waits a guard period, then opens a fixed observation window and counts per-channel activity.
- It also watches a monitored-domain reset that must stay low for the whole window, and reports a registered pass/fail verdict.
- It sits beside bus masters in bring-up and self-test builds; the verdict feeds status CSRs and the bench scoreboard.

## Interface
- NUM_CH, 2: number of monitored event channels (≥1).
- GUARD, 2: clock edges ignored after reset release (≥1).
- WINDOW, 10: observation window length in clock edges (≥1).
- CNT_W, 4: per-channel hit counter width (≥1).
- EARLY_EXIT, 0: 1 = close the window as soon as every channel has been seen.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ev  in  NUM_CH  event strobes, level-sampled once per edge.
- mon_rst  in  1  monitored-domain reset; must be low throughout the window.
- restart  in  1  re-arm request; honoured only in DONE.
- busy  out  1  state is GUARD or WINDOW.
- done  out  1  verdict valid.
- pass  out  1  done, all channels seen, no mon_rst violation.
- fail  out  1  done and not pass.
- mon_err  out  1  mon_rst sampled high inside the window (sticky until re-arm).
- seen  out  NUM_CH  channel i hit count ≠ 0.
- fail_ch  out  NUM_CH  ~seen while done, else 0.
- hit_cnt  out  NUM_CH*CNT_W  channel i count at [i*CNT_W +: CNT_W].

## Operation
- FSM states:
  - GUARD: count guard edges; ev and mon_rst are ignored.
  - WINDOW: sample ev and mon_rst on every edge.
  - DONE: hold all results.
- rst sampled high: state=GUARD, guard/window counters=0, hit_cnt=0, mon_err=0. Outputs: busy=1, done=pass=fail=0, seen=fail_ch=0.
- GUARD → WINDOW on the GUARD-th edge with rst low.
- In WINDOW, each edge:
  - hit_cnt[i] += ev[i], saturating at 2^CNT_W−1.
  - mon_err |= mon_rst.
- WINDOW → DONE on the WINDOW-th sampling edge, or earlier when EARLY_EXIT=1 and every channel's updated count is ≠ 0.
- Verdict:
  - done, pass, fail and fail_ch are registered on the same edge that enters DONE, and are computed from the updated counts and mon_err.
  - A mon_rst violation gives fail=1 even when all channels are seen.
- DONE: ev and mon_rst are ignored; all outputs are held.
- restart=1 in DONE → GUARD with every counter and flag cleared, exactly as on rst. restart in any other state has no effect.
- Priority: rst > restart > FSM advance.
- rst mid-window aborts the run: counts are discarded and the full guard restarts.

## Timing
- Let E0 be the edge where rst is sampled high, and E1, E2, … the following edges with rst low.
- Guard edges are E1…E_GUARD.
- Window sample k (k = 0…WINDOW−1) is taken at E_{GUARD+1+k}.
- Latency: done rises at E_{GUARD+WINDOW}, which is E12 at the defaults. Under EARLY_EXIT, done rises at the edge of the sample that completes coverage.
- Every output is a register output; there are no combinational paths from input to output.
- Events are seen one cycle late: an ev level at the edge is reflected in hit_cnt and seen after that edge.
- After restart at edge Er, done=0 from Er; the new verdict arrives at Er+GUARD+WINDOW.

## Test plan
- Coverage with defaults:
  - Stimulus: ev[0] high for one cycle at sample 2 (E5); ev[1] high for one cycle at sample 4 (E7).
  - Response: done=pass=1 at E12, hit_cnt={4'd1,4'd1}, fail_ch=2'b00, busy=0.
- Missing channel:
  - Stimulus: only ev[0] is pulsed.
  - Response: at E12, fail=1, pass=0, fail_ch=2'b10, hit_cnt[7:4]=0.
- Guard and post-done masking:
  - Stimulus: ev=2'b11 at E1, E2 and E13 only.
  - Response: hit_cnt=0, fail_ch=2'b11; counts unchanged after E13.
- mon_rst violation:
  - Stimulus: both channels hit; mon_rst high at E8.
  - Response: mon_err=1 from E8; at E12 fail=1, fail_ch=2'b00.
- Saturation with CNT_W=3:
  - Stimulus: ev[0] held high for the whole window.
  - Response: hit_cnt[2:0]=7 and no wrap.
  - Same stimulus with CNT_W=4 gives 10.
- EARLY_EXIT=1, mid-window rst, and restart:
  - Early exit: hits at samples 1 and 3 → done=pass=1 at E6.
  - Mid-window rst: a separate run with rst at E7 clears all outputs and restarts the guard.
  - Restart: restart in DONE re-arms the monitor; a second identical run gives an identical verdict GUARD+WINDOW edges after the restart edge.
